// File: rtl/unidade_controle_rodadas.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle_rodadas
// Purpose  : Control unit for the sequence-memory game with progressive
//            rounds. In round k+1 the player repeats positions 0..k of the
//            stored sequence. The unit owns the address, round and play-timeout
//            counters and drives the datapath with Moore outputs.
// Ports    : i_clock, i_reset (async, active-high)
//            i_iniciar      start/restart (only in inicial and final states)
//            i_jogada       one-cycle play pulse (only in espera_jogada)
//            i_igual        comparator result (only in compara_jogada)
//            i_modo_timeout enables the per-play timeout
//            o_zeraR, o_registraR    play-register control
//            o_endereco, o_rodada    position within round / round index
//            o_acertou, o_errou, o_timeout, o_pronto   result flags
//            o_db_estado             debug state code (C = illegal state)
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle_rodadas #(
    parameter int N_RODADAS = 16,
    parameter int TIMEOUT   = 3000,
    localparam int W        = $clog2(N_RODADAS)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_iniciar,
    input  logic         i_jogada,
    input  logic         i_igual,
    input  logic         i_modo_timeout,
    output logic         o_zeraR,
    output logic         o_registraR,
    output logic [W-1:0] o_endereco,
    output logic [W-1:0] o_rodada,
    output logic         o_acertou,
    output logic         o_errou,
    output logic         o_timeout,
    output logic         o_pronto,
    output logic [3:0]   o_db_estado
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  c_ULTIMA  = W'(N_RODADAS - 1);
    localparam logic [TW-1:0] c_TMAX    = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_INICIAL         = 4'h0,
        S_PREPARACAO      = 4'h1,
        S_INICIA_RODADA   = 4'h2,
        S_ESPERA_JOGADA   = 4'h3,
        S_REGISTRA_JOGADA = 4'h4,
        S_COMPARA_JOGADA  = 4'h5,
        S_PROXIMA_JOGADA  = 4'h6,
        S_PROXIMA_RODADA  = 4'h7,
        S_FINAL_TIMEOUT   = 4'hD,
        S_FINAL_ACERTOU   = 4'hE,
        S_FINAL_ERROU     = 4'hF
    } estado_t;

    estado_t       r_estado;
    estado_t       w_proximo;
    logic [W-1:0]  r_endereco;
    logic [W-1:0]  r_rodada;
    logic [TW-1:0] r_timer;
    logic [3:0]    w_db_estado;

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado <= S_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic
    always_comb begin
        w_proximo = S_INICIAL;
        case (r_estado)
            S_INICIAL:         w_proximo = i_iniciar ? S_PREPARACAO : S_INICIAL;
            S_PREPARACAO:      w_proximo = S_INICIA_RODADA;
            S_INICIA_RODADA:   w_proximo = S_ESPERA_JOGADA;
            S_ESPERA_JOGADA: begin
                // A play arriving on the last waiting cycle still counts.
                if (i_jogada)
                    w_proximo = S_REGISTRA_JOGADA;
                else if (i_modo_timeout && (r_timer == c_TMAX))
                    w_proximo = S_FINAL_TIMEOUT;
                else
                    w_proximo = S_ESPERA_JOGADA;
            end
            S_REGISTRA_JOGADA: w_proximo = S_COMPARA_JOGADA;
            S_COMPARA_JOGADA: begin
                if (!i_igual)
                    w_proximo = S_FINAL_ERROU;
                else if ((r_endereco == r_rodada) && (r_rodada == c_ULTIMA))
                    w_proximo = S_FINAL_ACERTOU;
                else if (r_endereco == r_rodada)
                    w_proximo = S_PROXIMA_RODADA;
                else
                    w_proximo = S_PROXIMA_JOGADA;
            end
            S_PROXIMA_JOGADA:  w_proximo = S_ESPERA_JOGADA;
            S_PROXIMA_RODADA:  w_proximo = S_INICIA_RODADA;
            S_FINAL_TIMEOUT,
            S_FINAL_ACERTOU,
            S_FINAL_ERROU:     w_proximo = i_iniciar ? S_PREPARACAO : r_estado;
            default:           w_proximo = S_INICIAL;
        endcase
    end

    // Counters change on the edge that leaves the state named in the case.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_endereco <= '0;
            r_rodada   <= '0;
            r_timer    <= '0;
        end else begin
            case (r_estado)
                S_PREPARACAO: begin
                    r_endereco <= '0;
                    r_rodada   <= '0;
                    r_timer    <= '0;
                end
                S_INICIA_RODADA: begin
                    r_endereco <= '0;
                    r_timer    <= '0;
                end
                S_PROXIMA_JOGADA: begin
                    r_endereco <= r_endereco + W'(1);
                    r_timer    <= '0;
                end
                S_PROXIMA_RODADA: begin
                    r_rodada <= r_rodada + W'(1);
                end
                S_ESPERA_JOGADA: begin
                    // Saturate so a disabled timeout never wraps the timer.
                    if (r_timer != c_TMAX)
                        r_timer <= r_timer + TW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Debug code: an illegal encoding reads as C for its single cycle.
    always_comb begin
        w_db_estado = 4'hC;
        case (r_estado)
            S_INICIAL, S_PREPARACAO, S_INICIA_RODADA, S_ESPERA_JOGADA,
            S_REGISTRA_JOGADA, S_COMPARA_JOGADA, S_PROXIMA_JOGADA,
            S_PROXIMA_RODADA, S_FINAL_TIMEOUT, S_FINAL_ACERTOU,
            S_FINAL_ERROU:     w_db_estado = r_estado;
            default:           w_db_estado = 4'hC;
        endcase
    end

    assign o_zeraR     = (r_estado == S_INICIAL) || (r_estado == S_PREPARACAO);
    assign o_registraR = (r_estado == S_REGISTRA_JOGADA);
    assign o_acertou   = (r_estado == S_FINAL_ACERTOU);
    assign o_errou     = (r_estado == S_FINAL_ERROU);
    assign o_timeout   = (r_estado == S_FINAL_TIMEOUT);
    assign o_pronto    = o_acertou || o_errou || o_timeout;
    assign o_endereco  = r_endereco;
    assign o_rodada    = r_rodada;
    assign o_db_estado = w_db_estado;

endmodule
`default_nettype wire

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Parametrised control unit for the sequence-memory game. Each round adds one play: the player repeats positions 0..r of the stored sequence. The block owns the address, round and timeout counters and drives the datapath (jogada register, sequence-memory address, comparator) with Moore outputs. It is the next generation of the single-pass game controller: configurable sequence length, progressive rounds and an optional play timeout.

## Interface
- N_RODADAS, 16: number of rounds and sequence length; must be ≥2. W = $clog2(N_RODADAS).
- TIMEOUT, 3000: clock cycles allowed per play in espera_jogada; must be ≥2. Timer width $clog2(TIMEOUT+1).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high. Forces inicial and clears all counters.
- iniciar  in  1  start/restart request. Sampled only in inicial and the final states.
- jogada  in  1  one-cycle play pulse from the edge detector. Sampled only in espera_jogada.
- igual  in  1  comparator result (registered play == memory[endereco]). Sampled only in compara_jogada.
- modo_timeout  in  1  1 enables the play timeout. Level, sampled in espera_jogada.
- zeraR  out  1  clears the play register.
- registraR  out  1  loads the play register.
- endereco  out  W  sequence-memory address (current position within the round).
- rodada  out  W  current round index; round k+1 is played when rodada = k.
- acertou / errou / timeout  out  1  one-hot result flags.
- pronto  out  1  high in any final state.
- db_estado  out  4  debug state code.

## Operation
- State codes (db_estado):
  - inicial 0
  - preparacao 1
  - inicia_rodada 2
  - espera_jogada 3
  - registra_jogada 4
  - compara_jogada 5
  - proxima_jogada 6
  - proxima_rodada 7
  - final_timeout D
  - final_acertou E
  - final_errou F
- Any unused encoding goes to inicial on the next clock. db_estado shows C while in an unused encoding.
- Transitions:
  - inicial: iniciar→preparacao, else stay.
  - preparacao→inicia_rodada.
  - inicia_rodada→espera_jogada.
  - espera_jogada: jogada→registra_jogada. Else if modo_timeout and timer==TIMEOUT−1→final_timeout. Else stay.
  - registra_jogada→compara_jogada.
  - compara_jogada: !igual→final_errou. igual and endereco==rodada and rodada==N_RODADAS−1→final_acertou. igual and endereco==rodada→proxima_rodada. igual otherwise→proxima_jogada.
  - proxima_jogada→espera_jogada.
  - proxima_rodada→inicia_rodada.
  - final_*: iniciar→preparacao, else stay.
- Counters (registered, updated on the clock edge leaving the named state):
  - preparacao: endereco=0, rodada=0, timer=0.
  - inicia_rodada: endereco=0, timer=0.
  - proxima_jogada: endereco+1, timer=0.
  - proxima_rodada: rodada+1.
  - espera_jogada: timer+1 (saturates at TIMEOUT−1).
  - All other states hold. endereco never exceeds rodada, so there is no wrap.
- Moore outputs, decoded from the state only:
  - zeraR = inicial|preparacao.
  - registraR = registra_jogada.
  - acertou = final_acertou; errou = final_errou; timeout = final_timeout.
  - pronto = any final state.
- Priority: jogada beats timeout in the same cycle. iniciar is ignored outside inicial and the final states. jogada is ignored outside espera_jogada.
- endereco and rodada hold their values in the final states, so the failing position is observable.

## Timing
- Reset values: state inicial, db_estado 0, zeraR 1, all other 1-bit outputs 0, endereco 0, rodada 0, timer 0. Reset takes effect immediately (asynchronous), including mid-round. The first state change after deassertion happens on a clock edge.
- Start: iniciar high at edge t in inicial → preparacao at t+1, inicia_rodada at t+2, espera_jogada at t+3.
- Correct, non-final play: jogada at edge t → registra t+1, compara t+2, proxima_jogada t+3, espera_jogada t+4 with endereco incremented.
- Round end: compara at t → proxima_rodada t+1, inicia_rodada t+2, espera_jogada t+3 with endereco=0.
- Timeout: espera_jogada entered at edge e with timer=0 and no jogada → final_timeout at edge e+TIMEOUT. The block spends exactly TIMEOUT cycles waiting.
- Flags assert in the cycle after the deciding compare or timeout edge and hold until iniciar or reset.

## Test plan
- Reset and idle: assert reset mid-cycle → db_estado=0, zeraR=1, endereco=0, rodada=0 at once. Hold iniciar=0 for 20 cycles → stays in 0.
- Full win (N_RODADAS=4, igual=1 always): 10 jogada pulses → db_estado=E, acertou=1, pronto=1, rodada=3, endereco=3.
- Error (N_RODADAS=4): igual=0 at round 3, position 1 → db_estado=F, errou=1, rodada=2, endereco=1. Then iniciar → preparacao, with endereco=0 and rodada=0 after inicia_rodada.
- Timeout (TIMEOUT=8, modo_timeout=1): no jogada → final_timeout exactly 8 cycles after entering espera_jogada, timeout=1. Same run with modo_timeout=0 → still in state 3 after 100 cycles.
- Simultaneous events (TIMEOUT=8): jogada on the 8th waiting cycle → registra_jogada, no timeout. iniciar pulses during espera_jogada and compara_jogada → ignored.
- Reset mid-round: reset asserted in compara_jogada, round 2 → inicial immediately, counters 0. A subsequent start behaves as a fresh game.
